ps2_rx: RTL and testbench

PS/2 device-to-host receiver that sits directly upstream of the keyboard Wishbone controller. It synchronises and deglitches the raw `PS2_CLK`/`PS2_DAT` lines and deserialises 11-bit frames: start, 8 data bits LSB first, odd parity, stop. Each good frame is delivered as a byte with a one-cycle `keyb_valid` strobe, the contract the scan-code translator consumes. Bad frames raise a one-cycle `keyb_error` and never produce `keyb_valid`.

---
 rtl/ps2_rx_if.sv | 10 +
 rtl/ps2_rx.sv | 124 ++++++++++++
 tb/tb_ps2_rx.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/ps2_rx_if.sv
// Received-byte bus from the PS/2 receiver to the keyboard scan-code translator.
// The receiver drives it through the master modport; consumers use the slave modport.
interface ps2_rx_if;
  logic [7:0] keyb_data;
  logic       keyb_valid;
  logic       keyb_error;

  modport master (output keyb_data, output keyb_valid, output keyb_error);
  modport slave  (input  keyb_data, input  keyb_valid, input  keyb_error);
endinterface

// File: rtl/ps2_rx.sv
// PS/2 device-to-host receiver: synchronises and deglitches PS2_CLK/PS2_DAT and
// deserialises 11-bit frames. Each good byte is reported with a one-cycle strobe.
module ps2_rx #(
  parameter int FILTER_LEN  = 8,     // 2..32
  parameter int TIMEOUT_CYC = 20000  // 16..2^20
) (
  input  logic     wb_clk,
  input  logic     sys_init,
  input  logic     PS2_CLK,
  input  logic     PS2_DAT,
  ps2_rx_if.master keyb
);

  typedef enum logic [1:0] {
    IDLE,
    RECV,
    CHECK
  } state_t;

  localparam logic [19:0] TIMEOUT_LAST = 20'(TIMEOUT_CYC - 1);

  logic [1:0]            clk_sync;
  logic [1:0]            dat_sync;
  logic [FILTER_LEN-1:0] clk_taps;
  logic                  fclk;
  logic                  fclk_prev;
  logic                  sample_ev;
  logic                  dat_s;

  state_t      state;
  logic [3:0]  bitcnt;
  logic [9:0]  shreg;
  logic [19:0] tcnt;
  logic [7:0]  data_q;
  logic        valid_q;
  logic        error_q;

  // Front end: both lines reset to 1 so an idle bus produces no spurious edge.
  always_ff @(posedge wb_clk) begin
    // NOTE: every clocked assignment is non-blocking so all registers update from
    // pre-edge values; blocking here would collapse the synchroniser chains.
    if (sys_init) begin
      clk_sync  <= 2'b11;
      dat_sync  <= 2'b11;
      clk_taps  <= '1;
      fclk      <= 1'b1;
      fclk_prev <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[0], PS2_CLK};
      dat_sync  <= {dat_sync[0], PS2_DAT};
      clk_taps  <= {clk_taps[FILTER_LEN-2:0], clk_sync[1]};
      if (~|clk_taps) begin
        fclk <= 1'b0;
      end else if (&clk_taps) begin
        fclk <= 1'b1;
      end
      fclk_prev <= fclk;
    end
  end

  assign sample_ev = fclk_prev & ~fclk;
  assign dat_s     = dat_sync[1];

  // Frame FSM. The stop bit lands in CHECK so the verdict is taken from the full
  // shift register one cycle later, with the result pulse registered.
  always_ff @(posedge wb_clk) begin
    if (sys_init) begin
      state   <= IDLE;
      bitcnt  <= 4'd0;
      shreg   <= 10'd0;
      tcnt    <= 20'd0;
      data_q  <= 8'h00;
      valid_q <= 1'b0;
      error_q <= 1'b0;
    end else begin
      // NOTE: the strobes default low every cycle, so each branch below only
      // needs to raise one; this is what keeps them exactly one cycle wide.
      valid_q <= 1'b0;
      error_q <= 1'b0;
      case (state)
        IDLE: begin
          tcnt <= 20'd0;
          if (sample_ev && !dat_s) begin
            state  <= RECV;
            bitcnt <= 4'd0;
          end
        end
        RECV: begin
          if (sample_ev) begin
            shreg  <= {dat_s, shreg[9:1]};
            bitcnt <= bitcnt + 4'd1;
            tcnt   <= 20'd0;
            if (bitcnt == 4'd9) begin
              state <= CHECK;
            end
          end else if (tcnt == TIMEOUT_LAST) begin
            error_q <= 1'b1;
            tcnt    <= 20'd0;
            state   <= IDLE;
          end else begin
            tcnt <= tcnt + 20'd1;
          end
        end
        CHECK: begin
          // shreg[7:0] data, shreg[8] odd parity, shreg[9] stop
          if ((^shreg[8:0]) && shreg[9]) begin
            data_q  <= shreg[7:0];
            valid_q <= 1'b1;
          end else begin
            error_q <= 1'b1;
          end
          tcnt  <= 20'd0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign keyb.keyb_data  = data_q;
  assign keyb.keyb_valid = valid_q;
  assign keyb.keyb_error = error_q;

endmodule

// File: tb/tb_ps2_rx.sv
// Directed bench for ps2_rx: drives PS/2 frames with a 40-cycle half-period and
// checks bytes, strobes, latency, glitch rejection, timeout and reset behaviour.
`timescale 1ns/1ps
module tb_ps2_rx;

  localparam int FL   = 8;
  localparam int TO   = 1000;
  localparam int HALF = 40;

  logic wb_clk = 1'b0;
  logic sys_init;
  logic ps2_clk;
  logic ps2_dat;

  ps2_rx_if keyb ();

  ps2_rx #(
    .FILTER_LEN (FL),
    .TIMEOUT_CYC(TO)
  ) dut (
    .wb_clk  (wb_clk),
    .sys_init(sys_init),
    .PS2_CLK (ps2_clk),
    .PS2_DAT (ps2_dat),
    .keyb    (keyb)
  );

  always #5 wb_clk = ~wb_clk;

  int cyc = 0;
  always @(posedge wb_clk) cyc <= cyc + 1;

  // Pulse monitor, sampled on the falling edge.
  int         valid_cnt = 0;
  int         err_cnt   = 0;
  int         valid_hi  = 0;
  int         err_hi    = 0;
  int         both_cnt  = 0;
  int         last_valid_cyc = 0;
  logic       valid_d = 1'b0;
  logic       err_d   = 1'b0;
  logic [7:0] got_q[$];

  always @(negedge wb_clk) begin
    if (keyb.keyb_valid === 1'b1) begin
      valid_hi++;
      if (!valid_d) begin
        valid_cnt++;
        got_q.push_back(keyb.keyb_data);
        last_valid_cyc = cyc;
      end
    end
    if (keyb.keyb_error === 1'b1) begin
      err_hi++;
      if (!err_d) err_cnt++;
    end
    if (keyb.keyb_valid === 1'b1 && keyb.keyb_error === 1'b1) both_cnt++;
    valid_d = (keyb.keyb_valid === 1'b1);
    err_d   = (keyb.keyb_error === 1'b1);
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge wb_clk);
  endtask

  task automatic ps2_bit(input logic b, output int fall_cyc);
    @(negedge wb_clk);
    ps2_dat = b;
    wait_cyc(HALF / 2);
    ps2_clk  = 1'b0;
    fall_cyc = cyc;
    wait_cyc(HALF);
    ps2_clk = 1'b1;
    wait_cyc(HALF / 2);
  endtask

  task automatic glitch();
    @(negedge wb_clk);
    ps2_clk = 1'b0;
    wait_cyc(3);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop,
                            input int glitch_after, output int stop_fall);
    int f;
    ps2_bit(1'b0, f);
    for (int i = 0; i < 8; i++) begin
      ps2_bit(d[i], f);
      if (i == glitch_after) begin
        glitch();
        wait_cyc(HALF / 2);
      end
    end
    ps2_bit(par, f);
    ps2_bit(stop, f);
    stop_fall = f;
    ps2_dat = 1'b1;
    wait_cyc(2 * HALF);
  endtask

  initial begin
    int sf;
    int v0;
    int e0;
    logic [7:0] part;

    ps2_clk  = 1'b1;
    ps2_dat  = 1'b1;
    sys_init = 1'b1;
    wait_cyc(4);
    sys_init = 1'b0;
    wait_cyc(2);

    // Reset state
    check("rst_data",  32'(keyb.keyb_data),  32'h00);
    check("rst_valid", 32'(keyb.keyb_valid), 32'd0);
    check("rst_error", 32'(keyb.keyb_error), 32'd0);
    check("rst_pulses", 32'(valid_cnt + err_cnt), 32'd0);

    // Good frame 0x1C with latency measured from the stop-bit fall
    send_frame(8'h1C, 1'b0, 1'b1, -1, sf);
    check("f1c_valid_cnt", 32'(valid_cnt), 32'd1);
    check("f1c_err_cnt",   32'(err_cnt),   32'd0);
    check("f1c_data",      32'(keyb.keyb_data), 32'h1C);
    check("f1c_latency",   32'(last_valid_cyc - (sf + 1)), 32'(FL + 4));

    // Back-to-back 0xE0 then 0x75
    send_frame(8'hE0, 1'b0, 1'b1, -1, sf);
    check("e0_data", 32'(keyb.keyb_data), 32'hE0);
    send_frame(8'h75, 1'b0, 1'b1, -1, sf);
    check("b2b_valid_cnt", 32'(valid_cnt), 32'd3);
    check("b2b_first",     32'(got_q[1]),  32'hE0);
    check("b2b_second",    32'(got_q[2]),  32'h75);
    check("b2b_data",      32'(keyb.keyb_data), 32'h75);

    // Parity error, then stop-bit error
    send_frame(8'h1C, 1'b1, 1'b1, -1, sf);
    check("par_err_cnt",   32'(err_cnt),   32'd1);
    check("par_valid_cnt", 32'(valid_cnt), 32'd3);
    check("par_data",      32'(keyb.keyb_data), 32'h75);
    send_frame(8'h1C, 1'b0, 1'b0, -1, sf);
    check("stop_err_cnt",   32'(err_cnt),   32'd2);
    check("stop_valid_cnt", 32'(valid_cnt), 32'd3);
    check("stop_data",      32'(keyb.keyb_data), 32'h75);

    // Short clock glitches while idle and mid-frame
    glitch();
    wait_cyc(HALF);
    send_frame(8'h5A, 1'b1, 1'b1, 3, sf);
    check("glitch_valid_cnt", 32'(valid_cnt), 32'd4);
    check("glitch_byte",      32'(got_q[3]),  32'h5A);
    check("glitch_err_cnt",   32'(err_cnt),   32'd2);

    // Truncated frame aborted by the timeout, then a clean frame
    ps2_bit(1'b0, sf);
    for (int i = 0; i < 4; i++) ps2_bit(1'(i[0]), sf);
    wait_cyc(TO + 10);
    check("to_err_cnt",   32'(err_cnt),   32'd3);
    check("to_valid_cnt", 32'(valid_cnt), 32'd4);
    send_frame(8'h29, 1'b0, 1'b1, -1, sf);
    check("after_to_valid_cnt", 32'(valid_cnt), 32'd5);
    check("after_to_data",      32'(keyb.keyb_data), 32'h29);
    check("after_to_err_cnt",   32'(err_cnt),   32'd3);

    // Reset after start + 4 data bits of 0x34
    part = 8'h34;
    ps2_bit(1'b0, sf);
    for (int i = 0; i < 4; i++) ps2_bit(part[i], sf);
    v0 = valid_cnt;
    e0 = err_cnt;
    sys_init = 1'b1;
    wait_cyc(1);
    check("in_rst_data",  32'(keyb.keyb_data),  32'h00);
    check("in_rst_valid", 32'(keyb.keyb_valid), 32'd0);
    check("in_rst_error", 32'(keyb.keyb_error), 32'd0);
    wait_cyc(1);
    sys_init = 1'b0;
    wait_cyc(1);
    check("post_rst_data", 32'(keyb.keyb_data), 32'h00);
    check("rst_no_pulse",  32'(valid_cnt + err_cnt), 32'(v0 + e0));
    for (int i = 4; i < 8; i++) ps2_bit(part[i], sf);
    ps2_bit(1'b0, sf);
    ps2_bit(1'b1, sf);
    ps2_dat = 1'b1;
    wait_cyc(TO + 100);
    check("rest_valid_cnt", 32'(valid_cnt), 32'(v0));
    check("rest_err_le1",   32'((err_cnt - e0) <= 1), 32'd1);
    send_frame(8'h12, 1'b1, 1'b1, -1, sf);
    check("fresh_valid_cnt", 32'(valid_cnt), 32'(v0 + 1));
    check("fresh_data",      32'(keyb.keyb_data), 32'h12);

    // Strobe shape over the whole run
    check("never_both",      32'(both_cnt), 32'd0);
    check("valid_one_cycle", 32'(valid_hi), 32'(valid_cnt));
    check("error_one_cycle", 32'(err_hi),   32'(err_cnt));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
